// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and uart_tx handshake bundle for uart_tx_arbiter
//
// Groups the requester valid/ready/data lanes with the uart_tx side
// (tx_din, tx_start, tx_done_tick).
//   slave  : arbiter view; consumes requests and tx_done_tick, drives ready and uart_tx inputs
//   master : environment view; requesters plus the uart_tx transmitter
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         tx_din;
  logic               tx_start;
  logic               tx_done_tick;

  modport slave (
    input  req_valid, req_data, tx_done_tick,
    output req_ready, tx_din, tx_start
  );

  modport master (
    output req_valid, req_data, tx_done_tick,
    input  req_ready, tx_din, tx_start
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx between N_REQ byte sources
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : slave side of uart_tx_arbiter_if (req_valid/req_data/req_ready,
//                  tx_din/tx_start to uart_tx, tx_done_tick from uart_tx)
//   busy         : high whenever the FSM is outside IDLE
//   grant_id     : index of the last accepted requester
//   timeout_err  : sticky, set when a frame sees no tx_done_tick in time
//   clear_err    : synchronous clear of timeout_err (a same-cycle timeout wins)
//   bytes_sent   : completed frame count, wraps at 16 bits
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int ID_W           = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_arbiter_if.slave    bus,
  output logic                busy,
  output logic [ID_W-1:0]     grant_id,
  output logic                timeout_err,
  input  logic                clear_err,
  output logic [15:0]         bytes_sent
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

  state_t           state;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  cand;
  logic [ID_W:0]    sum;
  logic             any_valid;
  logic [N_REQ-1:0] ready_onehot;
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;

  // Cyclic search starting just after last_grant; the first hit in that
  // order wins, so the most recently served requester has lowest priority.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, last_grant} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_REQ)) begin
        sum = sum - (ID_W+1)'(N_REQ);
      end
      cand = sum[ID_W-1:0];
      if (!any_valid && bus.req_valid[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  // Ready is combinational so a byte is accepted on the same edge it is seen.
  always_comb begin
    ready_onehot = '0;
    if (state == IDLE && any_valid) begin
      ready_onehot[winner] = 1'b1;
    end
  end

  assign bus.req_ready = ready_onehot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bus.tx_din   <= '0;
      bus.tx_start <= 1'b0;
      busy         <= 1'b0;
      grant_id     <= '0;
      timeout_err  <= 1'b0;
      bytes_sent   <= '0;
      last_grant   <= ID_W'(N_REQ - 1);
      to_cnt       <= '0;
      gap_cnt      <= '0;
    end else begin
      // A timeout set later in this block overrides the clear.
      if (clear_err) begin
        timeout_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (any_valid) begin
            bus.tx_din   <= bus.req_data[{winner, 3'b000} +: 8];
            grant_id     <= winner;
            last_grant   <= winner;
            bus.tx_start <= 1'b1;
            busy         <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          bus.tx_start <= 1'b0;
          to_cnt       <= '0;
          state        <= BUSY;
        end
        BUSY: begin
          if (bus.tx_done_tick || to_cnt == TO_LAST) begin
            if (bus.tx_done_tick) begin
              bytes_sent <= bytes_sent + 16'd1;
            end else begin
              timeout_err <= 1'b1;
            end
            gap_cnt <= '0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus0 ();
  uart_tx_arbiter_if #(.N_REQ(N)) bus1 ();

  logic            busy0, busy1, terr0, terr1;
  logic            clr0 = 1'b0;
  logic            clr1 = 1'b0;
  logic [ID_W-1:0] gid0, gid1;
  logic [15:0]     bs0, bs1;

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(0), .TIMEOUT_CYCLES(50)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .grant_id(gid0),
    .timeout_err(terr0), .clear_err(clr0), .bytes_sent(bs0)
  );

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(5), .TIMEOUT_CYCLES(200)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .grant_id(gid1),
    .timeout_err(terr1), .clear_err(clr1), .bytes_sent(bs1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard entries: {grant id, byte}
  logic [15:0] sb[$];
  logic [15:0] sb_head;

  task automatic push(input int id, input logic [7:0] d);
    sb.push_back({8'(id), d});
  endtask

  // requester model: pend[i] bytes outstanding, valid held until accepted
  int          pend[N] = '{default: 0};
  logic [N-1:0] acc = '0;
  always begin
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) pend[i]--;
    for (int i = 0; i < N; i++) bus0.req_valid[i] = (pend[i] != 0);
    #1;
    acc = bus0.req_ready & bus0.req_valid;
  end

  // uart_tx model: done tick 10 cycles after tx_start
  bit uart_en       = 1'b1;
  int last_done_cyc = -1;
  bit spacing_on    = 1'b0;
  always @(negedge clk) begin
    if (uart_en && bus0.tx_start) begin
      repeat (10) @(negedge clk);
      bus0.tx_done_tick = 1'b1;
      last_done_cyc     = cyc;
      @(negedge clk);
      bus0.tx_done_tick = 1'b0;
    end
  end

  // output monitor: each tx_start pops one expected grant
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (bus0.tx_start) begin
      check("start_width", 32'(prev_start), 0);
      check("busy_at_start", 32'(busy0), 1);
      if (spacing_on && last_done_cyc >= 0) check("b2b_spacing", cyc - last_done_cyc, 2);
      if (sb.size() == 0) begin
        check("sb_empty_at_start", sb.size(), 1);
      end else begin
        sb_head = sb.pop_front();
        check("tx_din", 32'(bus0.tx_din), 32'(sb_head[7:0]));
        check("grant_id", 32'(gid0), 32'(sb_head[15:8]));
      end
    end
    prev_start = bus0.tx_start;
  end

  task automatic wait_done(input int n, input string tag);
    int got = 0;
    for (int c = 0; c < 40 * n && got < n; c++) begin
      @(posedge clk);
      if (bus0.tx_done_tick) got++;
    end
    check(tag, got, n);
    @(negedge clk);
  endtask

  task automatic wait_start(input string tag);
    for (int c = 0; c < 40 && !bus0.tx_start; c++) @(negedge clk);
    check(tag, 32'(bus0.tx_start), 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 32'(busy0), 0);
    check({tag, "_start"}, 32'(bus0.tx_start), 0);
    check({tag, "_din"}, 32'(bus0.tx_din), 0);
    check({tag, "_gid"}, 32'(gid0), 0);
    check({tag, "_err"}, 32'(terr0), 0);
    check({tag, "_bytes"}, 32'(bs0), 0);
    check({tag, "_ready"}, 32'(bus0.req_ready), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus0.req_valid    = '0;
    bus0.req_data     = '0;
    bus0.tx_done_tick = 1'b0;
    bus1.req_valid    = '0;
    bus1.req_data     = '0;
    bus1.tx_done_tick = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;

    // single requester 2
    @(negedge clk);
    bus0.req_data = 32'h005A_0000;
    push(2, 8'h5A);
    pend[2] = 1;
    #2;
    check("t1_ready", 32'(bus0.req_ready), 32'h4);
    @(negedge clk);
    #2;
    check("t1_ready_drop", 32'(bus0.req_ready), 0);
    check("t1_start", 32'(bus0.tx_start), 1);
    check("t1_gid", 32'(gid0), 2);
    check("t1_din", 32'(bus0.tx_din), 32'h5A);
    wait_done(1, "t1_done");
    check("t1_busy_after_done", 32'(busy0), 0);
    check("t1_bytes", 32'(bs0), 1);

    // all four valid, back-to-back, order 0,1,2,3,0,1,2,3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t2_rst_bytes", 32'(bs0), 0);
    bus0.req_data = 32'h1312_1110;
    for (int i = 0; i < 8; i++) push(i % 4, 8'(16 + i % 4));
    last_done_cyc = -1;
    spacing_on    = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 2;
    wait_done(8, "t2_done");
    spacing_on = 1'b0;
    check("t2_bytes", 32'(bs0), 8);
    check("t2_sb_drained", sb.size(), 0);

    // fairness: last_grant=1, then 1 and 3 valid, 0 joins mid-frame
    bus0.req_data = 32'hD3C2_B1A0;
    push(1, 8'hB1);
    pend[1] = 1;
    wait_done(1, "t3_prime");
    push(3, 8'hD3);
    push(0, 8'hA0);
    push(1, 8'hB1);
    pend[1] = 1;
    pend[3] = 1;
    wait_start("t3_start3");
    pend[0] = 1;
    wait_done(3, "t3_done");
    check("t3_sb_drained", sb.size(), 0);
    check("t3_bytes", 32'(bs0), 12);

    // timeout: no done tick
    uart_en = 1'b0;
    push(0, 8'hA0);
    pend[0] = 1;
    wait_start("t4_start");
    repeat (50) @(negedge clk);
    check("t4_err_pre", 32'(terr0), 0);
    check("t4_busy_pre", 32'(busy0), 1);
    @(negedge clk);
    check("t4_err", 32'(terr0), 1);
    check("t4_busy", 32'(busy0), 0);
    check("t4_bytes", 32'(bs0), 12);
    bus0.tx_done_tick = 1'b1;
    @(negedge clk);
    bus0.tx_done_tick = 1'b0;
    @(negedge clk);
    check("t4_stray_bytes", 32'(bs0), 12);
    check("t4_stray_busy", 32'(busy0), 0);
    check("t4_err_hold", 32'(terr0), 1);
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    check("t4_clear", 32'(terr0), 0);
    uart_en = 1'b1;

    // gap of 5 cycles on dut1
    bus1.req_data  = 32'h0000_2211;
    bus1.req_valid = 4'b0011;
    #2;
    check("t5_ready0", 32'(bus1.req_ready), 1);
    @(negedge clk);
    bus1.req_valid = 4'b0010;
    check("t5_start0", 32'(bus1.tx_start), 1);
    check("t5_gid0", 32'(gid1), 0);
    check("t5_din0", 32'(bus1.tx_din), 32'h11);
    repeat (3) @(negedge clk);
    bus1.tx_done_tick = 1'b1;
    @(negedge clk);
    bus1.tx_done_tick = 1'b0;
    n = 1;
    while (bus1.req_ready == '0 && n < 20) begin
      if (n == 5) check("t5_busy_in_gap", 32'(busy1), 1);
      @(negedge clk);
      n++;
    end
    check("t5_gap_spacing", n, 6);
    check("t5_ready1", 32'(bus1.req_ready), 32'h2);
    check("t5_busy_idle", 32'(busy1), 0);
    check("t5_bytes", 32'(bs1), 1);
    @(negedge clk);
    bus1.req_valid = '0;
    check("t5_start1", 32'(bus1.tx_start), 1);
    check("t5_gid1", 32'(gid1), 1);
    check("t5_din1", 32'(bus1.tx_din), 32'h22);
    bus1.tx_done_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus1.tx_done_tick = 1'b0;

    // asynchronous reset mid-BUSY
    push(2, 8'hC2);
    pend[2] = 1;
    wait_start("t6_start");
    repeat (3) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset("t6_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);

    // bytes_sent wrap
    force dut0.bytes_sent = 16'hFFFF;
    @(negedge clk);
    release dut0.bytes_sent;
    @(negedge clk);
    check("wrap_preload", 32'(bs0), 32'hFFFF);
    push(1, 8'hB1);
    pend[1] = 1;
    wait_done(1, "wrap_done");
    check("wrap_bytes", 32'(bs0), 0);
    check("sb_final", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter between N_REQ byte requesters.
- Each requester uses a valid/ready handshake. Requesters are granted round-robin.
- The block latches the winning byte, drives din/tx_start into uart_tx, waits for tx_done_tick, then applies an optional inter-byte gap.
- Sits between the application byte sources and uart_tx, and replaces the free-running tx_start counter.

Parameters:
- N_REQ, 4, number of requesters, legal 2..8.
- GAP_CYCLES, 0, idle clk cycles inserted after each completed byte; 0 means no gap.
- TIMEOUT_CYCLES, 20000, clk cycles in BUSY without tx_done_tick before aborting; must be ≥ 2.
- ID_W, $clog2(N_REQ), derived width of grant_id; do not override.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  bit i: requester i holds a byte.
- req_data  input  8*N_REQ  byte i at [8*i+7:8*i]; stable while req_valid[i] is high.
- req_ready  output  N_REQ  bit i: byte i accepted on this edge (combinational).
- tx_din  output  8  byte to uart_tx din.
- tx_start  output  1  one-cycle start pulse to uart_tx.
- tx_done_tick  input  1  end-of-frame pulse from uart_tx.
- busy  output  1  high whenever state != IDLE.
- grant_id  output  ID_W  index of the last accepted requester.
- timeout_err  output  1  sticky flag: a frame timed out.
- clear_err  input  1  synchronous clear of timeout_err.
- bytes_sent  output  16  count of completed frames; wraps 0xFFFF→0.

Behaviour:
- Reset (asynchronous): all of the following take their reset values.
  - state=IDLE; tx_din=0; tx_start=0; busy=0; grant_id=0; timeout_err=0; bytes_sent=0.
  - last_grant=N_REQ-1, so requester 0 has first priority after reset.
  - Timeout and gap counters = 0.
- States: IDLE, START, BUSY, GAP. Encoding is free; no other reachable states.
- IDLE:
  - winner = first i with req_valid[i]=1, searching cyclically from last_grant+1.
  - req_ready = one-hot(winner) when any req_valid is high, else 0. Ready is 0 in all other states.
  - req_ready depends on req_valid; requesters must not make valid depend on ready.
  - On an edge with any valid: tx_din←req_data[winner]; grant_id←winner; last_grant←winner; →START.
- START: tx_start=1 for exactly this one cycle; timeout counter←0; →BUSY.
  - Latency: valid in IDLE at cycle n → ready at cycle n → tx_start at cycle n+1.
- BUSY:
  - tx_done_tick=1: bytes_sent+1; →GAP if GAP_CYCLES>0, else →IDLE.
  - Else if timeout counter == TIMEOUT_CYCLES-1: timeout_err←1; bytes_sent unchanged; same GAP/IDLE exit as above.
  - Else: counter+1.
  - tx_din stays stable throughout START and BUSY.
- GAP: count from 0 to GAP_CYCLES-1, then →IDLE. No grants are issued during GAP.
- tx_done_tick outside BUSY is ignored (no count, no state change).
- Error flag:
  - clear_err clears timeout_err on the next edge.
  - If clear_err and a new timeout occur in the same cycle, set wins.
- A requester that drops valid before it is granted loses nothing. A new valid in any state waits for IDLE.
- Back-to-back with GAP_CYCLES=0: done edge → IDLE. The next grant can occur in that IDLE cycle, so the minimum spacing is tx_done_tick → tx_start = 2 cycles.
- Reset mid-frame: immediate return to IDLE with all reset values. The in-flight byte is dropped and not counted.

Test Plan:
- Single requester: req_valid=4'b0100, byte 0x5A, model tx_done_tick 10 cycles after tx_start → required response:
  - req_ready=4'b0100 for one cycle, tx_start in the next cycle, tx_din=0x5A, grant_id=2.
  - bytes_sent=1; busy returns to 0 one cycle after the done tick.
- All four valid continuously, bytes 0x10/0x11/0x12/0x13, GAP_CYCLES=0 → grant order 0,1,2,3,0,…; bytes_sent=8 after 8 done ticks; tx_start never asserted while busy in BUSY.
- Round-robin fairness: requesters 1 and 3 valid, last_grant=1 → next grant 3, then 1; requester 0 asserting valid mid-frame is granted before 1 only if cyclic order from last_grant reaches it first.
- Timeout: TIMEOUT_CYCLES=50, never pulse tx_done_tick → timeout_err=1 exactly 50 cycles after entering BUSY; bytes_sent unchanged; clear_err returns it to 0; stray tx_done_tick in IDLE has no effect.
- Gap: GAP_CYCLES=5, two requesters valid → exactly 5 cycles of GAP plus 1 IDLE cycle between tx_done_tick and the next req_ready.
- Reset mid-BUSY, plus wrap: assert rst during BUSY → all outputs at reset values asynchronously, state IDLE. Separately, preload 0xFFFF completed frames (force) plus one more → bytes_sent=0x0000.
